// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues sequential imem addresses, captures the 1-cycle
// imem response, and queues {instruction, pc} for ID behind a valid/ready handshake.
module ifetch_queue #(
    parameter int            DEPTH    = 4,
    parameter int            AW       = 11,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                     w_clk,
    input  logic                     w_rst,
    input  logic                     w_redirect,
    input  logic [AW-1:0]            w_redirect_pc,
    input  logic                     w_halt,
    output logic [AW-1:0]            w_imem_addr,
    output logic                     w_imem_req,
    input  logic [DW-1:0]            w_imem_data,
    output logic                     w_valid,
    input  logic                     w_ready,
    output logic [DW-1:0]            w_ir,
    output logic [AW-1:0]            w_pc,
    output logic [AW-1:0]            w_pc4,
    output logic [$clog2(DEPTH):0]   w_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_fpc;
    logic          r_rsp_v;
    logic [AW-1:0] r_rsp_pc;
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_count;

    logic [DW-1:0] mem_ir [DEPTH];
    logic [AW-1:0] mem_pc [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   proj;

    // Handshake: the head transfers on any rising edge where w_valid && w_ready; w_valid
    // never depends on w_ready, and the head stays stable until it transfers or is flushed.
    always_comb begin
        pop   = (r_count != '0) && w_ready;
        push  = r_rsp_v && !w_redirect;
        // Occupancy after this edge if the outstanding response lands: keeps its slot reserved.
        proj  = {1'b0, r_count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, r_rsp_v};
        issue = !w_rst && !w_halt && !w_redirect && (proj < (CW+1)'(DEPTH));
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_fpc    <= RESET_PC;
            r_rsp_v  <= 1'b0;
            r_rsp_pc <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_fpc    <= w_redirect_pc;
            r_rsp_v  <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
        end else begin
            if (issue) begin
                r_rsp_v  <= 1'b1;
                r_rsp_pc <= r_fpc;
                r_fpc    <= r_fpc + AW'(1);
            end else begin
                r_rsp_v  <= 1'b0;
            end
            if (push) r_wp <= r_wp + PW'(1);
            if (pop)  r_rp <= r_rp + PW'(1);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge w_clk) begin
        if (push) begin
            mem_ir[r_wp] <= w_imem_data;
            mem_pc[r_wp] <= r_rsp_pc;
        end
    end

    // Storage is not reset, so the head fields are forced to zero whenever the queue is empty.
    assign w_valid     = (r_count != '0);
    assign w_ir        = w_valid ? mem_ir[r_rp] : '0;
    assign w_pc        = w_valid ? mem_pc[r_rp] : '0;
    assign w_pc4       = w_pc + AW'(1);
    assign w_imem_addr = r_fpc;
    assign w_imem_req  = issue;
    assign w_count     = r_count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: a queue-based reference model predicts every output
// each cycle, and scenario tasks add direct checks of ordering, latency and flush behaviour.
module tb_ifetch_queue;

    localparam int            DEPTH    = 4;
    localparam int            AW       = 11;
    localparam int            DW       = 32;
    localparam int            CW       = 3;
    localparam logic [AW-1:0] RESET_PC = '0;
    localparam int            VW       = 1 + CW + 1 + AW + DW + AW + AW;

    logic          clk;
    logic          rst;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    logic [AW-1:0] imem_addr;
    logic          imem_req;
    logic [DW-1:0] imem_data;
    logic          valid;
    logic          ready;
    logic [DW-1:0] ir;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
    logic [CW-1:0] count;

    int total;
    int bad;
    int cyc;

    logic [AW-1:0] m_q[$];
    logic [AW-1:0] m_fpc;
    logic          m_pend;
    logic [AW-1:0] m_pend_pc;
    logic          exp_pop;
    logic          exp_req;
    logic [VW-1:0] exp_vec;
    logic [VW-1:0] mask;
    logic [VW-1:0] obs;
    logic [VW-1:0] reset_vec;

    ifetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RESET_PC(RESET_PC)) dut (
        .w_clk(clk), .w_rst(rst), .w_redirect(redirect), .w_redirect_pc(redirect_pc),
        .w_halt(halt), .w_imem_addr(imem_addr), .w_imem_req(imem_req),
        .w_imem_data(imem_data), .w_valid(valid), .w_ready(ready), .w_ir(ir),
        .w_pc(pc), .w_pc4(pc4), .w_count(count)
    );

    assign obs       = {valid, count, imem_req, imem_addr, ir, pc, pc4};
    assign reset_vec = {1'b0, CW'(0), 1'b0, RESET_PC, DW'(0), AW'(0), AW'(1)};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory: word at addr holds 0x1000_0000 + addr.
    always @(posedge clk) imem_data <= 32'h1000_0000 + DW'(imem_addr);

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    task automatic model_reset();
        m_q.delete();
        m_fpc     = RESET_PC;
        m_pend    = 1'b0;
        m_pend_pc = '0;
    endtask

    task automatic model_expect();
        logic          ev;
        logic [AW-1:0] epc;
        int            occ;
        ev      = (m_q.size() != 0);
        epc     = ev ? m_q[0] : '0;
        exp_pop = ev && ready;
        occ     = m_q.size() - (exp_pop ? 1 : 0) + (m_pend ? 1 : 0);
        exp_req = !halt && !redirect && (occ < DEPTH);
        exp_vec = {ev, CW'(m_q.size()), exp_req, m_fpc, DW'(32'h1000_0000) + DW'(epc), epc, epc + AW'(1)};
        mask    = {1'b1, {CW{1'b1}}, 1'b1, {AW{1'b1}}, {(DW + 2*AW){ev}}};
    endtask

    task automatic model_edge();
        if (redirect) begin
            m_q.delete();
            m_pend = 1'b0;
            m_fpc  = redirect_pc;
        end else begin
            if (exp_pop) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_pend_pc);
            if (exp_req) begin
                m_pend    = 1'b1;
                m_pend_pc = m_fpc;
                m_fpc     = m_fpc + AW'(1);
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [AW-1:0] rpc, input logic h, input logic rd);
        redirect    = r;
        redirect_pc = rpc;
        halt        = h;
        ready       = rd;
        #1;
        model_expect();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (obs !== reset_vec) begin
            bad++;
            $display("FAIL reset_values got=%h exp=%h", obs, reset_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            total++;
            if ((obs & mask) !== (exp_vec & mask)) begin
                bad++;
                $display("FAIL reset_stream cyc=%0d got=%h exp=%h", cyc, obs & mask, exp_vec & mask);
            end
            total++;
            if (valid !== (k >= 2) || (k >= 2 && pc !== AW'(k - 2))) begin
                bad++;
                $display("FAIL reset_first_valid k=%0d got valid=%b pc=%h exp valid=%b pc=%h", k, valid, pc, (k >= 2), AW'(k - 2));
            end
            advance();
        end
    endtask

    task automatic test_full();
        logic [AW-1:0] nxt;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            total++;
            if ((obs & mask) !== (exp_vec & mask)) begin
                bad++;
                $display("FAIL full_fill cyc=%0d got=%h exp=%h", cyc, obs & mask, exp_vec & mask);
            end
            total++;
            if (count > CW'(DEPTH) || (k >= 4 && imem_req !== 1'b0) || (k >= 5 && count !== CW'(DEPTH))) begin
                bad++;
                $display("FAIL full_hold k=%0d got count=%0d req=%b exp count<=%0d req=0 after k>=4", k, count, imem_req, DEPTH);
            end
            advance();
        end
        nxt = '0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            total++;
            if ((obs & mask) !== (exp_vec & mask)) begin
                bad++;
                $display("FAIL full_drain cyc=%0d got=%h exp=%h", cyc, obs & mask, exp_vec & mask);
            end
            if (valid === 1'b1) begin
                total++;
                if (pc !== nxt || ir !== 32'h1000_0000 + DW'(nxt)) begin
                    bad++;
                    $display("FAIL full_order got pc=%h ir=%h exp pc=%h", pc, ir, nxt);
                end
                nxt = nxt + AW'(1);
            end
            advance();
        end
        total++;
        if (nxt < AW'(8)) begin
            bad++;
            $display("FAIL full_delivered got=%0d exp>=8", nxt);
        end
    endtask

    task automatic test_redirect();
        logic [AW-1:0] nxt;
        logic          rd;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, 11'h040, 1'b0, 1'b0);
        total++;
        if (count !== CW'(3) || (obs & mask) !== (exp_vec & mask)) begin
            bad++;
            $display("FAIL redir_pre got count=%0d vec=%h exp count=3 vec=%h", count, obs & mask, exp_vec & mask);
        end
        advance();
        drive(1'b0, '0, 1'b0, 1'b0);
        total++;
        if (count !== CW'(0) || imem_addr !== 11'h040 || imem_req !== 1'b1 || valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_next got count=%0d addr=%h req=%b valid=%b exp 0 040 1 0", count, imem_addr, imem_req, valid);
        end
        advance();
        drive(1'b0, '0, 1'b0, 1'b0);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_n2 got valid=%b exp 0", valid);
        end
        advance();
        nxt = 11'h040;
        for (int k = 0; k < 14; k++) begin
            rd = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            drive(1'b0, '0, 1'b0, rd);
            total++;
            if ((obs & mask) !== (exp_vec & mask) || (k == 0 && (valid !== 1'b1 || pc !== 11'h040))) begin
                bad++;
                $display("FAIL redir_stream k=%0d got=%h exp=%h", k, obs & mask, exp_vec & mask);
            end
            if (valid === 1'b1) begin
                total++;
                if (pc !== nxt) begin
                    bad++;
                    $display("FAIL redir_stale got pc=%h exp pc=%h", pc, nxt);
                end
                if (rd) nxt = nxt + AW'(1);
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] want [3];
        int            n;
        want[0] = 11'h7FF;
        want[1] = 11'h000;
        want[2] = 11'h001;
        n = 0;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            advance();
        end
        drive(1'b1, 11'h7FF, 1'b0, 1'b1);
        total++;
        if ((obs & mask) !== (exp_vec & mask)) begin
            bad++;
            $display("FAIL wrap_redirect got=%h exp=%h", obs & mask, exp_vec & mask);
        end
        advance();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            total++;
            if ((obs & mask) !== (exp_vec & mask)) begin
                bad++;
                $display("FAIL wrap_stream cyc=%0d got=%h exp=%h", cyc, obs & mask, exp_vec & mask);
            end
            if (valid === 1'b1 && n < 3) begin
                total++;
                if (pc !== want[n] || (want[n] == 11'h7FF && pc4 !== 11'h000)) begin
                    bad++;
                    $display("FAIL wrap_order n=%0d got pc=%h pc4=%h exp pc=%h", n, pc, pc4, want[n]);
                end
                n++;
            end
            advance();
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL wrap_count got=%0d exp=3", n);
        end
    endtask

    task automatic test_halt();
        int            got;
        logic [AW-1:0] nxt;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            advance();
        end
        got = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            total++;
            if ((obs & mask) !== (exp_vec & mask) || (k == 0 && count !== CW'(2))) begin
                bad++;
                $display("FAIL halt_drain k=%0d got=%h exp=%h", k, obs & mask, exp_vec & mask);
            end
            if (valid === 1'b1) got++;
            if (k == 5) begin
                total++;
                if (valid !== 1'b0 || imem_req !== 1'b0) begin
                    bad++;
                    $display("FAIL halt_idle got valid=%b req=%b exp 0 0", valid, imem_req);
                end
            end
            advance();
        end
        total++;
        if (got != 3) begin
            bad++;
            $display("FAIL halt_count got=%0d exp=3", got);
        end
        nxt = 11'h003;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            total++;
            if ((obs & mask) !== (exp_vec & mask)) begin
                bad++;
                $display("FAIL halt_resume cyc=%0d got=%h exp=%h", cyc, obs & mask, exp_vec & mask);
            end
            if (valid === 1'b1) begin
                total++;
                if (pc !== nxt) begin
                    bad++;
                    $display("FAIL halt_seq got pc=%h exp pc=%h", pc, nxt);
                end
                nxt = nxt + AW'(1);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            total++;
            if ((obs & mask) !== (exp_vec & mask) || (k >= 2 && (valid !== 1'b1 || pc !== AW'(k - 2)))) begin
                bad++;
                $display("FAIL b2b k=%0d got=%h exp=%h", k, obs & mask, exp_vec & mask);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            advance();
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== reset_vec) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", obs, reset_vec);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            total++;
            if ((obs & mask) !== (exp_vec & mask) || (k == 2 && (valid !== 1'b1 || pc !== RESET_PC))) begin
                bad++;
                $display("FAIL async_restart k=%0d got=%h exp=%h", k, obs & mask, exp_vec & mask);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic r;
        logic h;
        logic rd;
        apply_reset();
        for (int k = 0; k < 500; k++) begin
            r  = ($urandom_range(0, 15) == 0);
            h  = ($urandom_range(0, 7) == 0);
            rd = ($urandom_range(0, 2) != 0);
            drive(r, AW'($urandom_range(0, 2047)), h, rd);
            total++;
            if ((obs & mask) !== (exp_vec & mask)) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs & mask, exp_vec & mask);
            end
            advance();
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        ready = 1'b0;
        model_reset();
        test_reset();
        test_full();
        test_redirect();
        test_wrap();
        test_halt();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the ID stage of the 5-stage pipelined processor.
- Generates sequential instruction-memory addresses and captures the synchronous (1-cycle read latency) instruction-memory output into a small FIFO.
- Presents instructions to ID through a valid/ready handshake, so ID interlocks no longer need to freeze the PC.
- Accepts a redirect (mispredict or predicted-taken target) that flushes all queued and in-flight fetches.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- AW, 11, word-address width of the PC and instruction memory.
- DW, 32, instruction width.
- RESET_PC, 0, fetch address after reset.

Ports:
- w_clk  in  1  clock; all state updates on the rising edge.
- w_rst  in  1  reset; asynchronous, active-high.
- w_redirect  in  1  flush queue and restart fetch at w_redirect_pc.
- w_redirect_pc  in  AW  restart word address.
- w_halt  in  1  suppress new fetch issue.
- w_imem_addr  out  AW  instruction memory address; equals r_fpc.
- w_imem_req  out  1  address this cycle is a real fetch.
- w_imem_data  in  DW  instruction memory read data; valid the cycle after a request.
- w_valid  out  1  head entry valid.
- w_ready  in  1  ID accepts the head this cycle.
- w_ir  out  DW  head instruction.
- w_pc  out  AW  head PC.
- w_pc4  out  AW  w_pc+1, modulo 2^AW.
- w_count  out  log2(DEPTH)+1  occupancy.

Behaviour:
- State:
  - r_fpc: next fetch PC.
  - r_rsp_v / r_rsp_pc: one outstanding response and its PC.
  - FIFO storage with read/write pointers and r_count.
- Reset (asynchronous):
  - r_fpc=RESET_PC, r_rsp_v=0, r_rsp_pc=0.
  - Pointers=0, r_count=0.
  - Resulting outputs: w_valid=0, w_count=0, w_ir=0, w_pc=0, w_pc4=1, w_imem_req=0 during reset.
- Pop: pop = w_valid && w_ready. Head advances on the edge.
- Issue:
  - Condition: w_imem_req = !w_rst && !w_halt && !w_redirect && (r_count - pop + r_rsp_v) < DEPTH.
  - On issue: r_rsp_v<=1, r_rsp_pc<=r_fpc, r_fpc<=r_fpc+1. PC wraps from 2^AW-1 to 0.
  - No issue: r_rsp_v<=0 and r_fpc holds.
- Push:
  - Condition: r_rsp_v && !w_redirect.
  - Writes {w_imem_data, r_rsp_pc} at the tail.
  - The issue rule guarantees a push never overflows. The bench asserts this.
- Occupancy:
  - Push and pop in the same cycle leave the count unchanged.
  - Pop from empty cannot occur, because w_valid=0 when empty.
- No bypass: an instruction is visible on w_ir one cycle after its data returns. Latency from issue to w_valid is 2 cycles.
- Redirect (highest priority):
  - On the edge: pointers=0, r_count=0, r_rsp_v=0 (in-flight response discarded), r_fpc<=w_redirect_pc.
  - A pop in the same cycle still completes; ID has latched the head.
  - Timing: redirect in cycle n → cycle n+1 empty with w_imem_addr=target and w_imem_req=1 (if not halted) → w_valid=1 with the target in cycle n+3.
- Halt:
  - Stops issuing only.
  - A pending response still pushes, and the queue drains via pops.
  - Deasserting halt resumes issue at r_fpc.
- Reset mid-operation: abandons all state immediately, without waiting for a clock edge.
- Sustained throughput: with w_ready=1 and no redirect or halt, one instruction per cycle after the 2-cycle fill.
- Queue full and ready low: issue stops. The in-flight fetch still has a reserved slot.

Test Plan:
- Bench imem returns 32'h1000_0000+addr. Release reset with w_ready=1 → w_valid first high in cycle 2 after release; pc 0,1,2,3… on consecutive cycles; w_ir=32'h1000_0000+pc; w_pc4=pc+1.
- Hold w_ready=0 from release → w_count reaches 4 and stays; w_imem_req=0 once count+pending=4. Raise w_ready → pcs 0..7 delivered in order with no gaps or duplicates.
- Pulse w_redirect with w_redirect_pc=11'h040 while count=3 and a response is pending → next cycle w_count=0 and w_imem_addr=0x040; pc 0x040 valid 3 cycles after the pulse. No stale pc (0x003 etc.) ever appears.
- Redirect with w_redirect_pc=11'h7FF, w_ready=1 → delivered pcs 0x7FF, 0x000, 0x001; w_pc4 for 0x7FF reads 0x000.
- w_halt=1 with 2 queued and 1 pending → 3 instructions drain, then w_valid=0 and w_imem_req=0. Release halt → fetch resumes at the next sequential pc.
- Assert w_rst asynchronously mid-stream, between clock edges → w_valid and w_count drop to 0 at once. After release, fetch restarts at RESET_PC=0.
